muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core.
- Sits beside the EXE-stage ALU and executes mult/multu/div/divu, plus mthi/mtlo writes.
- Its busy output stalls the pipeline while an operation runs.
- Generalises the single-cycle ALU path: width is parametrised and operations take several cycles under a start/busy/done handshake.

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the MIPS HI/LO registers.
// Shift-add multiply and restoring divide run on magnitudes; signs are applied in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic               zero_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign sgn      = ~op[0];
    assign a_neg    = sgn & a[WIDTH-1];
    assign b_neg    = sgn & b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign zero_div = op[1] & (b == '0);

    // Multiply: acc_hi:acc_lo is the product register, multiplier bits consumed from acc_lo[0].
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quot_fix = neg_q ? -acc_lo : acc_lo;
    assign rem_fix  = neg_r ? -acc_hi : acc_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = zero_div ? FIX : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(1)) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= CW'(WIDTH);
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dbz    <= zero_div;
                        acc_hi <= '0;
                        acc_lo <= op[1] ? a_mag : b_mag;
                        opnd   <= op[1] ? b_mag : a_mag;
                    end else begin
                        if (mthi) begin
                            hi <= wdata;
                        end
                        if (mtlo) begin
                            lo <= wdata;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    // A zero divisor leaves HI/LO untouched; dbz doubles as that marker.
                    if (!dbz) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, corner-case sequences and random ops
// checked against an arithmetic reference model; a second WIDTH=8 instance covers the narrow case.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        mthi8;
    logic        mtlo8;
    logic [7:0]  wdata8;
    logic        busy8;
    logic        done8;
    logic        dbz8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int total;
    int bad;

    logic [31:0] mhi;
    logic [31:0] mlo;
    logic        mdbz;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[7];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .mthi(mthi8), .mtlo(mtlo8), .wdata(wdata8),
        .busy(busy8), .done(done8), .dbz(dbz8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating division as SystemVerilog defines it.
    task automatic ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] h_in, input logic [31:0] l_in,
                          output logic [31:0] h, output logic [31:0] l, output logic d);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        h  = h_in;
        l  = l_in;
        d  = 1'b0;
        case (o)
            2'b00: begin p = 64'(sx * sy); {h, l} = p; end
            2'b01: begin p = {32'd0, x} * {32'd0, y}; {h, l} = p; end
            2'b10: begin
                if (y == 32'd0) d = 1'b1;
                else begin l = 32'(sx / sy); h = 32'(sx % sy); end
            end
            default: begin
                if (y == 32'd0) d = 1'b1;
                else begin l = x / y; h = x % y; end
            end
        endcase
    endtask

    // Called at the negedge just after the start edge; returns at the done cycle.
    task automatic waitDone(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        forever begin
            if (busy) bcnt++;
            if (done) break;
            if (lat >= 100) begin
                lat = -1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        waitDone(lat, bcnt);
    endtask

    task automatic doWrite(input logic h, input logic l, input logic [31:0] d);
        @(negedge clk);
        mthi  = h;
        mtlo  = l;
        wdata = d;
        @(negedge clk);
        mthi  = 1'b0;
        mtlo  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        int          bcnt;
        int          dones;
        int          exp_lat;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        wh;
        logic        wl;
        logic [31:0] wd;

        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        mthi8 = 1'b0; mtlo8 = 1'b0; wdata8 = '0;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_hi",   hi,          32'd0);
        checkOutput("reset_lo",   lo,          32'd0);
        checkOutput("reset_busy", 32'(busy),   32'd0);
        checkOutput("reset_done", 32'(done),   32'd0);
        checkOutput("reset_dbz",  32'(dbz),    32'd0);
        mhi = '0; mlo = '0; mdbz = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            checkOutput($sformatf("vec%0d_hi", i),   hi,          vecs[i].hi);
            checkOutput($sformatf("vec%0d_lo", i),   lo,          vecs[i].lo);
            checkOutput($sformatf("vec%0d_dbz", i),  32'(dbz),    32'd0);
            checkOutput($sformatf("vec%0d_lat", i),  32'(lat),    32'd33);
            checkOutput($sformatf("vec%0d_busy", i), 32'(bcnt),   32'd33);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_pulse", i), 32'(done),  32'd0);
            mhi = vecs[i].hi;
            mlo = vecs[i].lo;
        end

        $display("[TB] divide by zero");
        doWrite(1'b1, 1'b0, 32'h0000_1234);
        mhi = 32'h0000_1234;
        checkOutput("mthi_write", hi, mhi);
        applyStimulus(2'b11, 32'd7, 32'd0, lat, bcnt);
        checkOutput("dbz_lat",  32'(lat),  32'd1);
        checkOutput("dbz_busy", 32'(bcnt), 32'd1);
        checkOutput("dbz_flag", 32'(dbz),  32'd1);
        checkOutput("dbz_hi",   hi,        mhi);
        checkOutput("dbz_lo",   lo,        mlo);
        repeat (3) @(negedge clk);
        checkOutput("dbz_sticky", 32'(dbz), 32'd1);
        applyStimulus(2'b01, 32'd3, 32'd5, lat, bcnt);
        checkOutput("dbz_clear", 32'(dbz), 32'd0);
        checkOutput("after_dbz_lo", lo, 32'd15);
        checkOutput("after_dbz_hi", hi, 32'd0);
        mhi = 32'd0; mlo = 32'd15;

        $display("[TB] busy interactions");
        prev_hi = hi;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 5) begin
                start = 1'b1; a = 32'd9; b = 32'd9; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (k == 6) begin
                start = 1'b0; mthi = 1'b0;
            end
            if (k == 8) checkOutput("mthi_while_busy", hi, prev_hi);
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("busy_start_dones", 32'(dones), 32'd1);
        checkOutput("busy_start_hi", hi, 32'd0);
        checkOutput("busy_start_lo", lo, 32'd42);

        prev_lo = lo;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'h0001_0000; b = 32'h0001_0000;
        mtlo = 1'b1; wdata = 32'h0000_ABCD;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        checkOutput("start_mtlo_lo_hold", lo, prev_lo);
        waitDone(lat, bcnt);
        checkOutput("start_mtlo_lat", 32'(lat), 32'd33);
        checkOutput("start_mtlo_hi", hi, 32'd1);
        checkOutput("start_mtlo_lo", lo, 32'd0);
        doWrite(1'b1, 1'b1, 32'h5A5A_0F0F);
        checkOutput("mthi_mtlo_hi", hi, 32'h5A5A_0F0F);
        checkOutput("mthi_mtlo_lo", lo, 32'h5A5A_0F0F);

        $display("[TB] reset mid-operation");
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_hi",   hi,        32'd0);
        checkOutput("abort_lo",   lo,        32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("abort_no_done", 32'(dones), 32'd0);
        applyStimulus(2'b01, 32'd3, 32'd5, lat, bcnt);
        checkOutput("post_abort_lat", 32'(lat), 32'd33);
        checkOutput("post_abort_lo",  lo,       32'd15);
        mhi = hi; mlo = lo; mdbz = 1'b0;
        mhi = 32'd0; mlo = 32'd15;

        $display("[TB] WIDTH=8 divu");
        @(negedge clk);
        start8 = 1'b1; op8 = 2'b11; a8 = 8'd200; b8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("w8_lat", 32'(lat), 32'd9);
        checkOutput("w8_lo",  32'(lo8), 32'd28);
        checkOutput("w8_hi",  32'(hi8), 32'd4);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wh = 1'($urandom_range(0, 1));
                wl = wh ? 1'($urandom_range(0, 1)) : 1'b1;
                wd = $urandom;
                doWrite(wh, wl, wd);
                if (wh) mhi = wd;
                if (wl) mlo = wd;
                checkOutput($sformatf("rnd%0d_wr_hi", i), hi, mhi);
                checkOutput($sformatf("rnd%0d_wr_lo", i), lo, mlo);
            end
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'h8000_0000;
                3:       rb = 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            ref_op(ro, ra, rb, mhi, mlo, eh, el, ed);
            exp_lat = (ro[1] && rb == 32'd0) ? 1 : 33;
            applyStimulus(ro, ra, rb, lat, bcnt);
            checkOutput($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, ro, ra, rb), hi, eh);
            checkOutput($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, ro, ra, rb), lo, el);
            checkOutput($sformatf("rnd%0d_dbz", i), 32'(dbz), 32'(ed));
            checkOutput($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat));
            checkOutput($sformatf("rnd%0d_busy", i), 32'(bcnt), 32'(exp_lat));
            mhi = eh; mlo = el; mdbz = ed;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
